char_stream_tx: RTL and testbench

//   Transmit side of the ASCII character-stream interface consumed by the sequence checker.
//   A host loads up to DEPTH 8-bit characters (e.g. "1","0","1"...) into an internal buffer.
//   On start, the block replays the buffer (REPEAT+1) times, one character per accepted beat.

---
 rtl/char_stream_tx.sv | 127 ++++++++++++
 tb/tb_char_stream_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_stream_tx.sv
// char_stream_tx: transmit side of the ASCII character-stream interface.
//
// A host fills an internal buffer with up to DEPTH characters while idle. A start
// replays the buffer (repeat_cnt+1) times over a valid/ready stream, one character
// per accepted beat. A one-cycle done pulse follows the final transfer.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   wr_en/wr_data  append a character at the buffer tail (idle only)
//   clr          empty the buffer (idle only, beats wr_en/start)
//   start        begin a run (idle, effective count non-zero)
//   repeat_cnt   extra passes, captured when start is accepted
//   full/count   buffer occupancy
//   busy         run in progress (SEND or DONE)
//   out_char/out_valid/out_ready  character stream handshake
//   done         one-cycle pulse after the last transfer
module char_stream_tx #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned REPEAT_W = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     clr,
   input  logic                     start,
   input  logic [REPEAT_W-1:0]      repeat_cnt,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic [7:0]               out_char,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     done
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;

   typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       count_q, count_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [REPEAT_W-1:0] pass_q, pass_d;
   logic [7:0]          buf_q [DEPTH];
   logic                wr_fire;
   logic                xfer;
   logic                last_idx;

   assign full     = (count_q == CW'(DEPTH));
   assign xfer     = (state_q == StSend) && out_ready;
   // Count is stable during a run, so the last index is simply count-1.
   assign last_idx = ({1'b0, idx_q} == (count_q - CW'(1)));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      wr_fire = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (clr) begin
               count_d = '0;
            end else begin
               if (wr_en && !full) begin
                  wr_fire = 1'b1;
                  count_d = count_q + CW'(1);
               end
               // count_d already includes a same-cycle write.
               if (start && (count_d != '0)) begin
                  state_d = StSend;
                  idx_d   = '0;
                  pass_d  = repeat_cnt;
               end
            end
         end
         StSend: begin
            if (xfer) begin
               if (!last_idx) begin
                  idx_d = idx_q + IW'(1);
               end else if (pass_q != '0) begin
                  idx_d  = '0;
                  pass_d = pass_q - REPEAT_W'(1);
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         count_q <= '0;
         idx_q   <= '0;
         pass_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
      end
   end

   // Buffer storage needs no reset; contents are only read below count.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         buf_q[count_q[IW-1:0]] <= wr_data;
      end
   end

   assign count     = count_q;
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StSend);
   assign out_char  = (state_q == StSend) ? buf_q[idx_q] : 8'h00;
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_char_stream_tx.sv
// tb_char_stream_tx: table-driven directed bench for char_stream_tx, plus hand-written
// sequences for repeat replay, buffer overflow and asynchronous reset mid-run.
module tb_char_stream_tx;

   localparam int unsigned DEPTH    = 16;
   localparam int unsigned REPEAT_W = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                wr_en;
   logic [7:0]          wr_data;
   logic                clr;
   logic                start;
   logic [REPEAT_W-1:0] repeat_cnt;
   logic                full;
   logic [4:0]          count;
   logic                busy;
   logic [7:0]          out_char;
   logic                out_valid;
   logic                out_ready;
   logic                done;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   char_stream_tx #(
      .DEPTH   (DEPTH),
      .REPEAT_W(REPEAT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .clr       (clr),
      .start     (start),
      .repeat_cnt(repeat_cnt),
      .full      (full),
      .count     (count),
      .busy      (busy),
      .out_char  (out_char),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done)
   );

   typedef struct {
      logic       wr;
      logic [7:0] d;
      logic       cl;
      logic       st;
      logic [3:0] rep;
      logic       rdy;
      logic [4:0] e_cnt;
      logic       e_full;
      logic       e_busy;
      logic       e_valid;
      logic [7:0] e_char;
      logic       e_done;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic wr, logic [7:0] d, logic cl, logic st, logic [3:0] rep,
                               logic rdy, logic [4:0] e_cnt, logic e_full, logic e_busy,
                               logic e_valid, logic [7:0] e_char, logic e_done);
      vec_t v;
      v.wr = wr; v.d = d; v.cl = cl; v.st = st; v.rep = rep; v.rdy = rdy;
      v.e_cnt = e_cnt; v.e_full = e_full; v.e_busy = e_busy; v.e_valid = e_valid;
      v.e_char = e_char; v.e_done = e_done;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_data = 8'h00; clr = 0; start = 0; repeat_cnt = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      bit seen_done;

      // Row: wr d clr st rep rdy | cnt full busy valid char done
      // Test 1: "101", write of the last char in the same cycle as start.
      tbl.push_back(mk(1, 8'h31, 0, 0, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 8'h30, 0, 0, 0, 1,  2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 8'h31, 0, 1, 0, 1,  3, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 1, 0, 8'h00, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 0, 0, 8'h00, 0));
      // Test 2: stalls; wr/clr/start while busy must be ignored.
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0,  3, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(1, 8'h58, 0, 0, 0, 0,  3, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  3, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 5, 1,  3, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  3, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 1, 0, 8'h00, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  3, 0, 0, 0, 8'h00, 0));
      // Test 5: clr wins over start; start on empty buffer ignored.
      tbl.push_back(mk(1, 8'h41, 1, 1, 0, 1,  0, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1,  0, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0));
      // Test 3: "10" with repeat_cnt=2, no gaps across pass wraps.
      tbl.push_back(mk(1, 8'h31, 0, 0, 0, 1,  1, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(1, 8'h30, 0, 0, 0, 1,  2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 8'h00, 0, 1, 2, 1,  2, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 1, 8'h31, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 1, 8'h30, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 1, 0, 8'h00, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  2, 0, 0, 0, 8'h00, 0));

      // Reset state, checked before any clock edge.
      rst_n = 0; out_ready = 0;
      idle_inputs();
      #2;
      chk("reset count", count, 0);
      chk("reset full", full, 0);
      chk("reset busy", busy, 0);
      chk("reset valid", out_valid, 0);
      chk("reset char", out_char, 8'h00);
      chk("reset done", done, 0);
      step();
      step();
      rst_n = 1;

      foreach (tbl[i]) begin
         wr_en = tbl[i].wr; wr_data = tbl[i].d; clr = tbl[i].cl; start = tbl[i].st;
         repeat_cnt = tbl[i].rep; out_ready = tbl[i].rdy;
         step();
         chk($sformatf("row%0d count", i), count, tbl[i].e_cnt);
         chk($sformatf("row%0d full", i), full, tbl[i].e_full);
         chk($sformatf("row%0d busy", i), busy, tbl[i].e_busy);
         chk($sformatf("row%0d valid", i), out_valid, tbl[i].e_valid);
         chk($sformatf("row%0d char", i), out_char, tbl[i].e_char);
         chk($sformatf("row%0d done", i), done, tbl[i].e_done);
      end
      idle_inputs();

      // Test 3 continued: second start replays the same 6 beats.
      start = 1; repeat_cnt = 2; out_ready = 1;
      step();
      idle_inputs();
      beats = 0; seen_done = 0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         if (out_valid) begin
            chk($sformatf("replay beat%0d", beats), out_char,
                (beats % 2 == 0) ? 8'h31 : 8'h30);
            beats++;
         end
         if (done) seen_done = 1;
         else step();
      end
      chk("replay beats", beats, 6);
      chk("replay done seen", seen_done, 1);
      step();

      // Test 4: overflow; 17th write dropped, writes during a run ignored.
      clr = 1;
      step();
      clr = 0;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1; wr_data = 8'h41 + 8'(i);
         step();
         if (i == 14) chk("fill15 full", full, 0);
         if (i == 15) begin
            chk("fill16 full", full, 1);
            chk("fill16 count", count, 16);
         end
      end
      chk("fill17 count", count, 16);
      chk("fill17 full", full, 1);
      wr_en = 0;
      start = 1; repeat_cnt = 0; out_ready = 1;
      step();
      start = 0;
      wr_en = 1; wr_data = 8'h7a;
      beats = 0; seen_done = 0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         if (out_valid) begin
            chk($sformatf("full beat%0d", beats), out_char, 8'h41 + 8'(beats));
            beats++;
         end
         if (done) seen_done = 1;
         else step();
      end
      chk("full beats", beats, 16);
      chk("full done seen", seen_done, 1);
      chk("busy write count", count, 16);
      idle_inputs();
      step();

      // Test 6: async reset during the second beat of a 5-char run.
      clr = 1;
      step();
      clr = 0;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1; wr_data = 8'h31 + 8'(i);
         step();
      end
      wr_en = 0;
      start = 1; out_ready = 1;
      step();
      start = 0;
      step();
      chk("beat2 char", out_char, 8'h32);
      #2;
      rst_n = 0;
      #1;
      chk("async valid", out_valid, 0);
      chk("async busy", busy, 0);
      chk("async count", count, 0);
      chk("async char", out_char, 8'h00);
      chk("async done", done, 0);
      seen_done = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done) seen_done = 1;
      end
      rst_n = 1;
      for (int c = 0; c < 3; c++) begin
         step();
         if (done || busy) seen_done = 1;
      end
      chk("post reset no done", seen_done, 0);
      chk("post reset count", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
